game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_state_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//   Top-level sequencer for the dino game. Tracks the game phase, keeps the
//   running BCD score and the best score since reset, and flags when the best
//   score is beaten.
//
//   Ports
//     clk         system clock, all state updates on its rising edge
//     rst         asynchronous, active-low reset
//     start_btn   debounced start button level (clk domain)
//     collision   dino/obstacle overlap level (clk domain)
//     game_tick   divided game clock level (derived from clk)
//     game_state  current phase: 0=INIT 1=START 2=END 3=RESET
//     score       running score, 4-digit BCD, digit 3 in [15:12]
//     high_score  best score since reset, 4-digit BCD
//     new_high    one-cycle pulse on the first END cycle when high_score is replaced
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | idle, score 0, waiting for a fresh start press
//   START | game running, score counts game_tick rising edges
//   END   | game over, score frozen; presses ignored until holdoff elapses
//   RESET | score cleared, dwell RESET_CYCLES cycles then back to INIT
module game_state_ctrl #(
  parameter int HOLDOFF_CYCLES = 100000000,
  parameter int RESET_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        collision,
  input  logic        game_tick,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        new_high
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;
  localparam logic [1:0] ST_RESET = 2'd3;

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;
  localparam int RCNT_W = $clog2(RESET_CYCLES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

  localparam logic [15:0] SCORE_MAX = 16'h9999;

  logic [1:0]        state_q, state_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_q, high_d;
  logic              new_high_q, new_high_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic              btn_q, btn_d;
  logic              tick_q, tick_d;
  logic              btn_rise;
  logic              tick_rise;

  // Ripple BCD increment: each digit wraps 9->0 and carries into the next.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign btn_rise  = start_btn & ~btn_q;
  assign tick_rise = game_tick & ~tick_q;

  always_comb begin
    btn_d      = start_btn;
    tick_d     = game_tick;
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = 1'b0;
    hold_cnt_d = hold_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    case (state_q)
      ST_INIT: begin
        score_d = '0;
        if (btn_rise) state_d = ST_START;
      end
      ST_START: begin
        // Collision wins over a same-cycle tick so the final score is the
        // one displayed when the hit happened.
        if (collision) begin
          state_d    = ST_END;
          hold_cnt_d = '0;
          // BCD digits order the same as binary, so a plain compare works.
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
        end else if (tick_rise && (score_q != SCORE_MAX)) begin
          score_d = bcd_inc(score_q);
        end
      end
      ST_END: begin
        if (hold_cnt_q == HOLD_MAX) begin
          if (btn_rise) begin
            state_d   = ST_RESET;
            score_d   = '0;
            rst_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RESET: begin
        score_d = '0;
        if (rst_cnt_q >= RCNT_LAST) begin
          state_d = ST_INIT;
        end else begin
          rst_cnt_d = rst_cnt_q + RCNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // btn_q resets high so a button held through reset release is not a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      hold_cnt_q <= '0;
      rst_cnt_q  <= '0;
      btn_q      <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      hold_cnt_q <= hold_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      btn_q      <= btn_d;
      tick_q     <= tick_d;
    end
  end

  assign game_state = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;
  localparam int HOLD = 10;
  localparam int RCYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0;
  logic        collision = 1'b0;
  logic        game_tick = 1'b0;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        new_high;

  int vectors = 0;
  int errors  = 0;

  // Reference model: phase, decimal score values and elapsed-cycle counts.
  logic [1:0] m_state;
  int         m_score, m_high, m_end_cyc, m_rst_cyc;
  bit         m_new, m_btn_prev, m_tick_prev;

  always #5 clk = ~clk;

  game_state_ctrl #(.HOLDOFF_CYCLES(HOLD), .RESET_CYCLES(RCYC)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .collision(collision),
    .game_tick(game_tick), .game_state(game_state), .score(score),
    .high_score(high_score), .new_high(new_high)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_state = 2'd0; m_score = 0; m_high = 0; m_new = 1'b0;
    m_end_cyc = 0; m_rst_cyc = 0; m_btn_prev = 1'b1; m_tick_prev = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit b, input bit c, input bit t);
    bit rise, trise;
    @(negedge clk);
    start_btn = b; collision = c; game_tick = t;
    rise  = b && !m_btn_prev;
    trise = t && !m_tick_prev;
    m_new = 1'b0;
    case (m_state)
      2'd0: if (rise) m_state = 2'd1;
      2'd1: begin
        if (c) begin
          if (m_score > m_high) begin m_high = m_score; m_new = 1'b1; end
          m_state = 2'd2; m_end_cyc = 0;
        end else if (trise && m_score < 9999) m_score++;
      end
      2'd2: begin
        if (rise && m_end_cyc >= HOLD) begin m_state = 2'd3; m_score = 0; m_rst_cyc = 0; end
        m_end_cyc++;
      end
      default: begin
        m_rst_cyc++;
        if (m_rst_cyc == RCYC) m_state = 2'd0;
      end
    endcase
    m_btn_prev = b; m_tick_prev = t;
    @(posedge clk); #1;
  endtask

  task automatic play_ticks(input int n, input bit fast, input string tag);
    int hi, lo;
    for (int i = 0; i < n; i++) begin
      hi = fast ? 1 : int'($urandom_range(1, 3));
      lo = fast ? 1 : int'($urandom_range(1, 3));
      for (int k = 0; k < hi + lo; k++) begin
        step(fast ? 1'b0 : bit'($urandom_range(0, 1)), 1'b0, k < hi);
        vectors++;
        if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
          errors++;
          $display("FAIL %s state=%0d exp %0d score=%h exp %h high=%h exp %h new_high=%b exp %b",
                   tag, game_state, m_state, score, to_bcd(m_score), high_score, to_bcd(m_high), new_high, m_new);
        end
      end
    end
  endtask

  task automatic start_game(input string tag);
    bit seq[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(seq[i], 1'b0, 1'b0);
      vectors++;
      if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
        errors++;
        $display("FAIL %s state=%0d exp %0d score=%h exp %h high=%h exp %h",
                 tag, game_state, m_state, score, to_bcd(m_score), high_score, to_bcd(m_high));
      end
    end
  endtask

  task automatic return_home(input string tag);
    for (int i = 0; i < HOLD + 2; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
      vectors++;
      if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
        errors++;
        $display("FAIL %s_end state=%0d exp %0d score=%h exp %h high=%h exp %h",
                 tag, game_state, m_state, score, to_bcd(m_score), high_score, to_bcd(m_high));
      end
    end
    if (m_state == 2'd2) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < RCYC + 2; i++) begin
      step(1'b0, bit'($urandom_range(0, 1)), 1'b0);
      vectors++;
      if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
        errors++;
        $display("FAIL %s_reset state=%0d exp %0d score=%h exp %h high=%h exp %h",
                 tag, game_state, m_state, score, to_bcd(m_score), high_score, to_bcd(m_high));
      end
    end
    vectors++;
    if (game_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_home state=%0d exp 0", tag, game_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_btn = 1'b0; collision = 1'b0; game_tick = 1'b0;
    model_reset();
    #2;
    vectors++;
    if ({game_state, score, high_score, new_high} !== 35'd0) begin
      errors++;
      $display("FAIL reset_async state=%0d score=%h high=%h new_high=%b exp all 0", game_state, score, high_score, new_high);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
        errors++;
        $display("FAIL reset_idle state=%0d exp %0d score=%h exp %h", game_state, m_state, score, to_bcd(m_score));
      end
    end
  endtask

  task automatic test_basic_game();
    start_game("basic_start");
    play_ticks(12, 1'b0, "basic_ticks");
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({game_state, score, high_score, new_high} !== {2'd2, 16'h0012, 16'h0012, 1'b1}) begin
      errors++;
      $display("FAIL basic_collide state=%0d exp 2 score=%h exp 0012 high=%h exp 0012 new_high=%b exp 1",
               game_state, score, high_score, new_high);
    end
  endtask

  task automatic test_holdoff();
    int rst_seen = 0;
    int nh_seen  = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(cyc == 3 || cyc == 11, 1'b0, 1'b0);
      if (new_high) nh_seen++;
      vectors++;
      if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
        errors++;
        $display("FAIL holdoff_cyc%0d state=%0d exp %0d score=%h exp %h", cyc, game_state, m_state, score, to_bcd(m_score));
      end
      if (cyc == 3) begin
        vectors++;
        if (game_state !== 2'd2) begin
          errors++;
          $display("FAIL holdoff_early_press state=%0d exp 2", game_state);
        end
      end
    end
    vectors++;
    if (nh_seen != 0) begin
      errors++;
      $display("FAIL holdoff_new_high pulses=%0d exp 0", nh_seen);
    end
    if (game_state == 2'd3) rst_seen++;
    for (int i = 0; i < RCYC; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (game_state == 2'd3) rst_seen++;
      vectors++;
      if (score !== 16'h0000) begin
        errors++;
        $display("FAIL holdoff_reset_score score=%h exp 0000", score);
      end
    end
    vectors++;
    if (rst_seen != RCYC) begin
      errors++;
      $display("FAIL holdoff_reset_len cycles=%0d exp %0d", rst_seen, RCYC);
    end
    vectors++;
    if ({game_state, high_score} !== {2'd0, 16'h0012}) begin
      errors++;
      $display("FAIL holdoff_home state=%0d exp 0 high=%h exp 0012", game_state, high_score);
    end
  endtask

  task automatic test_second_game();
    int nh_seen = 0;
    start_game("second_start");
    play_ticks(7, 1'b0, "second_ticks");
    step(1'b0, 1'b1, 1'b0);
    if (new_high) nh_seen++;
    vectors++;
    if ({game_state, score, high_score, nh_seen} !== {2'd2, 16'h0007, 16'h0012, 32'd0}) begin
      errors++;
      $display("FAIL second_end state=%0d exp 2 score=%h exp 0007 high=%h exp 0012 new_high_pulses=%0d exp 0",
               game_state, score, high_score, nh_seen);
    end
    return_home("second");
  endtask

  task automatic test_same_cycle();
    start_game("same_start");
    play_ticks(5, 1'b0, "same_ticks");
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if ({game_state, score} !== {2'd2, 16'h0005}) begin
      errors++;
      $display("FAIL same_cycle state=%0d exp 2 score=%h exp 0005", game_state, score);
    end
    return_home("same");
  endtask

  task automatic test_carry_saturation();
    start_game("sat_start");
    play_ticks(999, 1'b1, "sat_preload");
    vectors++;
    if (score !== 16'h0999) begin errors++; $display("FAIL sat_0999 score=%h exp 0999", score); end
    play_ticks(1, 1'b1, "sat_carry");
    vectors++;
    if (score !== 16'h1000) begin errors++; $display("FAIL sat_carry score=%h exp 1000", score); end
    play_ticks(8999, 1'b1, "sat_fill");
    vectors++;
    if (score !== 16'h9999) begin errors++; $display("FAIL sat_9999 score=%h exp 9999", score); end
    play_ticks(2, 1'b0, "sat_hold");
    vectors++;
    if (score !== 16'h9999) begin errors++; $display("FAIL sat_saturate score=%h exp 9999", score); end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({game_state, high_score, new_high} !== {2'd2, 16'h9999, 1'b1}) begin
      errors++;
      $display("FAIL sat_end state=%0d exp 2 high=%h exp 9999 new_high=%b exp 1", game_state, high_score, new_high);
    end
  endtask

  task automatic test_btn_held_reset();
    start_btn = 1'b1;
    rst = 1'b0;
    model_reset();
    #2;
    vectors++;
    if ({game_state, score, high_score, new_high} !== 35'd0) begin
      errors++;
      $display("FAIL held_async state=%0d score=%h high=%h new_high=%b exp all 0", game_state, score, high_score, new_high);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (game_state !== 2'd0) begin
        errors++;
        $display("FAIL held_stays_init state=%0d exp 0", game_state);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    vectors++;
    if (game_state !== 2'd1) begin
      errors++;
      $display("FAIL held_fresh_press state=%0d exp 1", game_state);
    end
    play_ticks(3, 1'b0, "held_ticks");
    rst = 1'b0;
    model_reset();
    #2;
    vectors++;
    if ({game_state, score, high_score, new_high} !== 35'd0) begin
      errors++;
      $display("FAIL midgame_async state=%0d score=%h high=%h new_high=%b exp all 0", game_state, score, high_score, new_high);
    end
    start_btn = 1'b0;
    @(negedge clk) rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({game_state, score, high_score, new_high} !== {m_state, to_bcd(m_score), to_bcd(m_high), m_new}) begin
      errors++;
      $display("FAIL midgame_after state=%0d exp %0d score=%h exp %h", game_state, m_state, score, to_bcd(m_score));
    end
  endtask

  initial begin
    test_reset();
    test_basic_game();
    test_holdoff();
    test_second_game();
    test_same_cycle();
    test_carry_saturation();
    test_btn_held_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
